fp_norm_stage: RTL and testbench
================================

FP_NORM_STAGE -- requirements
Module: fp_norm_stage

Interface
REQ-001 Parameter EXP_W, default 8: exponent width, biased unsigned.
REQ-002 Parameter MANT_W, fixed at 16: mantissa width; shift amounts are 4 bits plus a zero flag.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream operand valid.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_sign  input  1  operand sign, passed through unchanged.
REQ-008 in_exp  input  EXP_W  operand biased exponent.
REQ-009 in_mant  input  16  unnormalised mantissa; bit 15 is the MSB.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_sign  output  1  result sign.
REQ-013 out_exp  output  EXP_W  adjusted exponent.
REQ-014 out_mant  output  16  left-shifted mantissa.
REQ-015 out_zero  output  1  result mantissa is zero.
REQ-016 out_uflow  output  1  normalisation was limited by the exponent.

Function
REQ-017 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
REQ-018 Two-register pipeline: S1 registers operand plus lzc (leading zeros of in_mant, 0..16); S2 registers the shifted result; latency from input transfer to out_valid is exactly 2 cycles when not stalled.
REQ-019 Throughput is one operand per cycle while out_ready stays high.
REQ-020 Stall: S2 holds while out_valid && !out_ready; S1 advances into S2 only when S2 is empty or being drained that cycle; in_ready = !S1_valid || S1 advances.
REQ-021 in_ready depends on out_ready combinationally (no skid buffer); no other input-to-output combinational path.
REQ-022 Held outputs stay stable while out_valid && !out_ready.
REQ-023 Normal case (in_mant != 0, in_exp > lzc): shift = lzc, out_exp = in_exp - lzc, out_mant[15] = 1, out_uflow = 0.
REQ-024 Underflow case (in_mant != 0, in_exp <= lzc): shift = in_exp, out_exp = 0, out_uflow = 1.
REQ-025 Zero case (in_mant == 0): out_mant = 0, out_exp = 0, out_zero = 1, out_uflow = 0; out_sign still passes through.
REQ-026 The shift is logical left with zero fill; the shift amount is always <= 15 whenever in_mant != 0.
REQ-027 Exponent subtraction is EXP_W wide and never wraps; REQ-023/024 guarantee this.
REQ-028 out_zero and out_uflow are never both 1.

Reset
REQ-029 While rst is high at a clock edge: both stage valids clear, and out_valid, out_sign, out_exp, out_mant, out_zero and out_uflow are 0.
REQ-030 While rst is high, in_ready is 0; it is 1 on the first cycle after rst deasserts.
REQ-031 Reset mid-operation discards in-flight operands; no output transfer occurs for them.

Structure
REQ-032 Shared package holds MANT_W, the lzc width constant (5) and the default EXP_W.
REQ-033 One sub-module, lzc16: combinational 16-bit leading-zero counter, output 0..16.
REQ-034 The shifter is a 16-bit, 4-level log shifter inside fp_norm_stage.

Verification
REQ-035 in_mant=16'h0001, in_exp=20 -> after 2 cycles: out_mant=16'h8000, out_exp=5, out_uflow=0, out_zero=0.
REQ-036 in_mant=16'h00F0, in_exp=3 -> out_mant=16'h0780, out_exp=0, out_uflow=1.
REQ-037 in_mant=0, in_exp=100, in_sign=1 -> out_mant=0, out_exp=0, out_zero=1, out_sign=1.
REQ-038 Back-to-back stream of 8 operands with out_ready held low for cycles 3-6 -> in_ready drops when both stages are full; no loss or duplication; results arrive in order; outputs are stable during the stall.
REQ-039 in_mant=16'h8000, in_exp=1 -> out_mant=16'h8000, out_exp=1, latency 2 cycles.
REQ-040 Assert rst for one cycle with both stages full -> out_valid=0 the next cycle, in_ready=1 the cycle after, and a new operand then completes normally.

Source files
------------

// File: rtl/fp_norm_stage_pkg.sv
// Shared constants and the stage-1 bundle for the mantissa
// normaliser pipeline.
package fp_norm_stage_pkg;

  localparam int MANT_W    = 16;
  localparam int LZC_W     = 5;
  localparam int EXP_W_DEF = 8;

  typedef struct packed {
    logic              sign;
    logic [MANT_W-1:0] mant;
    logic [LZC_W-1:0]  lzc;
  } s1_core_t;

endpackage

// File: rtl/fp_norm_stage_lzc16.sv
// 16-bit leading-zero counter; an all-zero input yields 16,
// so bit 4 of the count doubles as the zero flag.
module lzc16
  import fp_norm_stage_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [LZC_W-1:0]  count
);

  always_comb begin
    count = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) count = LZC_W'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_stage.sv
// Two-stage mantissa normaliser: S1 holds operand + lzc,
// S2 holds the shifted, exponent-adjusted result.
module fp_norm_stage
  import fp_norm_stage_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_uflow
);

  localparam int CMP_W = (EXP_W > LZC_W) ? EXP_W : LZC_W;

  logic [LZC_W-1:0] in_lzc;

  logic             s1_v;
  s1_core_t         s1;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_adv;

  logic              s2_v;
  logic              s2_sign;
  logic [EXP_W-1:0]  s2_exp;
  logic [MANT_W-1:0] s2_mant;
  logic              s2_zero;
  logic              s2_uflow;

  logic [CMP_W-1:0]  exp_ext;
  logic [CMP_W-1:0]  lzc_ext;
  logic              is_zero;
  logic              norm;
  logic [3:0]        sh;
  logic [MANT_W-1:0] l1;
  logic [MANT_W-1:0] l2;
  logic [MANT_W-1:0] l3;
  logic [MANT_W-1:0] l4;
  logic [EXP_W-1:0]  n_exp;
  logic [MANT_W-1:0] n_mant;
  logic              n_uflow;

  lzc16 u_lzc (
    .mant  (in_mant),
    .count (in_lzc)
  );

  // no skid buffer: S1 frees up in the same cycle S2 drains
  assign s1_adv   = s1_v && (!s2_v || out_ready);
  assign in_ready = !rst && (!s1_v || s1_adv);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1     <= '0;
      s1_exp <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1.sign <= in_sign;
        s1.mant <= in_mant;
        s1.lzc  <= in_lzc;
        s1_exp  <= in_exp;
      end
    end
  end

  assign exp_ext = CMP_W'(s1_exp);
  assign lzc_ext = CMP_W'(s1.lzc);
  assign is_zero = s1.lzc[LZC_W-1];
  assign norm    = exp_ext > lzc_ext;

  // underflow stops the shift where the exponent reaches 0
  assign sh = norm ? s1.lzc[3:0] : 4'(s1_exp);

  assign l1 = sh[0] ? {s1.mant[MANT_W-2:0], 1'b0} : s1.mant;
  assign l2 = sh[1] ? {l1[MANT_W-3:0], 2'b0} : l1;
  assign l3 = sh[2] ? {l2[MANT_W-5:0], 4'b0} : l2;
  assign l4 = sh[3] ? {l3[MANT_W-9:0], 8'b0} : l3;

  always_comb begin
    n_exp   = '0;
    n_mant  = '0;
    n_uflow = 1'b0;
    if (!is_zero) begin
      n_mant  = l4;
      n_uflow = !norm;
      if (norm) n_exp = s1_exp - EXP_W'(s1.lzc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_mant  <= '0;
      s2_zero  <= 1'b0;
      s2_uflow <= 1'b0;
    end else if (s1_adv) begin
      s2_v     <= 1'b1;
      s2_sign  <= s1.sign;
      s2_exp   <= n_exp;
      s2_mant  <= n_mant;
      s2_zero  <= is_zero;
      s2_uflow <= n_uflow;
    end else if (out_ready) begin
      s2_v <= 1'b0;
    end
  end

  assign out_valid = s2_v;
  assign out_sign  = s2_sign;
  assign out_exp   = s2_exp;
  assign out_mant  = s2_mant;
  assign out_zero  = s2_zero;
  assign out_uflow = s2_uflow;

endmodule

// File: tb/tb_fp_norm_stage.sv
// Randomised + directed bench for fp_norm_stage against an
// arithmetic reference model and an in-order scoreboard.
module tb_fp_norm_stage;

  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [15:0]   in_mant;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [15:0]   out_mant;
  logic          out_zero;
  logic          out_uflow;

  int checks = 0;
  int errors = 0;

  logic [26:0] q[$];
  logic        held = 1'b0;
  logic [26:0] prev;

  always #5 clk = ~clk;

  fp_norm_stage #(.EXP_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [26:0] pack(input logic s,
    input logic [EW-1:0] e, input logic [15:0] m,
    input logic z, input logic u);
    return {s, e, m, z, u};
  endfunction

  function automatic logic [26:0] pack_out();
    return pack(out_sign, out_exp, out_mant, out_zero, out_uflow);
  endfunction

  function automatic logic [26:0] model(input logic s,
    input logic [EW-1:0] e, input logic [15:0] m);
    int lz;
    int ei;
    lz = 0;
    while (lz < 16 && m[15-lz] == 1'b0) lz++;
    ei = int'(e);
    if (m == 16'h0)
      return pack(s, '0, '0, 1'b1, 1'b0);
    else if (ei > lz)
      return pack(s, EW'(ei - lz), 16'(m << lz), 1'b0, 1'b0);
    else
      return pack(s, '0, 16'(m << ei), 1'b0, 1'b1);
  endfunction

  task automatic drive(input logic v, input logic s,
    input logic [EW-1:0] e, input logic [15:0] m,
    input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    out_ready = ordy;
    #1;
    acc = 1'b0;
    if (rst) begin
      held = 1'b0;
      q.delete();
    end else begin
      if (held) chk("hold_stable", pack_out(), prev);
      if (out_valid) chk("zero_uflow_excl", out_zero & out_uflow, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else chk("data", pack_out(), q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(s, e, m));
        acc = 1'b1;
      end
      held = out_valid && !out_ready;
      prev = pack_out();
    end
  endtask

  task automatic idle(input logic ordy);
    logic a;
    drive(1'b0, 1'b0, '0, '0, ordy, a);
  endtask

  task automatic directed(input string tag, input logic s,
    input logic [EW-1:0] e, input logic [15:0] m,
    input logic [26:0] want);
    logic a;
    int lat;
    drive(1'b1, s, e, m, 1'b1, a);
    chk({tag, "_acc"}, a, 1);
    lat = 0;
    while (lat < 10) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, a);
      lat++;
      if (out_valid) break;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_val"}, pack_out(), want);
  endtask

  initial begin
    logic a;
    int sent;
    int guard;
    logic saw_drop;
    logic [15:0] m;
    logic [EW-1:0] e;

    rst = 1'b1;
    idle(1'b1);
    idle(1'b1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outs", {out_valid, pack_out()}, 0);

    rst = 1'b0;
    idle(1'b1);
    chk("post_rst_in_ready", in_ready, 1);

    directed("r035", 1'b0, 8'd20, 16'h0001,
             pack(1'b0, 8'd5, 16'h8000, 1'b0, 1'b0));
    directed("r036", 1'b0, 8'd3, 16'h00F0,
             pack(1'b0, 8'd0, 16'h0780, 1'b0, 1'b1));
    directed("r037", 1'b1, 8'd100, 16'h0000,
             pack(1'b1, 8'd0, 16'h0000, 1'b1, 1'b0));
    directed("r039", 1'b0, 8'd1, 16'h8000,
             pack(1'b0, 8'd1, 16'h8000, 1'b0, 1'b0));
    directed("eq_lzc", 1'b1, 8'd4, 16'h0F00,
             pack(1'b1, 8'd0, 16'hF000, 1'b0, 1'b1));
    directed("exp0", 1'b0, 8'd0, 16'h0123,
             pack(1'b0, 8'd0, 16'h0123, 1'b0, 1'b1));

    sent = 0;
    saw_drop = 1'b0;
    for (int c = 0; c < 40 && (sent < 8 || q.size() != 0); c++) begin
      m = 16'($urandom);
      m = m >> $urandom_range(0, 15);
      e = EW'($urandom_range(0, 40));
      drive(sent < 8, $urandom_range(0, 1) == 1, e, m,
            !(c >= 3 && c <= 6), a);
      if (sent < 8 && !in_ready) saw_drop = 1'b1;
      if (a) sent++;
    end
    chk("stream_sent", sent, 8);
    chk("stream_backpressure", saw_drop, 1);
    chk("stream_drained", q.size(), 0);

    for (int c = 0; c < 3000; c++) begin
      m = 16'($urandom);
      m = m >> $urandom_range(0, 16);
      if ($urandom_range(0, 1) == 1) e = EW'($urandom_range(0, 20));
      else e = EW'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            e, m, $urandom_range(0, 3) != 0, a);
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    chk("rand_drained", q.size(), 0);

    drive(1'b1, 1'b0, 8'd9, 16'h0010, 1'b0, a);
    drive(1'b1, 1'b1, 8'd9, 16'h0020, 1'b0, a);
    drive(1'b1, 1'b1, 8'd9, 16'h0040, 1'b0, a);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    rst = 1'b1;
    idle(1'b0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    idle(1'b1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready1", in_ready, 1);
    idle(1'b1);
    chk("mid_rst_no_out", out_valid, 0);
    directed("after_rst", 1'b1, 8'd30, 16'h0404,
             pack(1'b1, 8'd25, 16'h8080, 1'b0, 1'b0));
    idle(1'b1);
    chk("final_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
